// File: rtl/regfile_scoreboard.sv
// Two-read / one-write register file with a per-register pending-write scoreboard.
// Read data and busy flags are registered; an optional same-edge write is forwarded to the read ports.
module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    input  logic              RE,
    input  logic [ADDR_W-1:0] A3,
    input  logic [DATA_W-1:0] WD,
    input  logic              RegWrite,
    input  logic              ISSUE,
    input  logic [ADDR_W-1:0] IA,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    output logic              BUSY1,
    output logic              BUSY2
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_reg [DEPTH];
    logic [DEPTH-1:0]  pend_reg;
    logic [DEPTH-1:0]  pend_next;
    logic [DATA_W-1:0] rd1_reg, rd2_reg;
    logic [DATA_W-1:0] rd1_next, rd2_next;
    logic              busy1_reg, busy2_reg;
    logic              write_en;

    assign write_en = RegWrite && !((ZERO_REG != 0) && (A3 == '0));

    // Issue wins over a same-cycle retire: the new producer supersedes the old one.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_pend
            localparam logic [ADDR_W-1:0] IDX       = ADDR_W'(gi);
            localparam bit                HARD_ZERO = (ZERO_REG != 0) && (gi == 0);
            logic hit_write;
            logic hit_issue;
            assign hit_write     = RegWrite && (A3 == IDX);
            assign hit_issue     = ISSUE && (IA == IDX);
            assign pend_next[gi] = !HARD_ZERO && ((pend_reg[gi] && !hit_write) || hit_issue);
        end
    endgenerate

    function automatic logic [DATA_W-1:0] read_sel(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] stored,
        input logic              wr,
        input logic [ADDR_W-1:0] waddr,
        input logic [DATA_W-1:0] wdata
    );
        logic [DATA_W-1:0] value;
        value = stored;
        if ((ZERO_REG != 0) && (addr == '0)) begin
            value = '0;
        end else if ((BYPASS != 0) && wr && (waddr == addr)) begin
            value = wdata;
        end
        return value;
    endfunction

    always_comb begin
        rd1_next = read_sel(A1, regs_reg[A1], RegWrite, A3, WD);
        rd2_next = read_sel(A2, regs_reg[A2], RegWrite, A3, WD);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (write_en) begin
            regs_reg[A3] <= WD;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pend_reg <= '0;
        end else begin
            pend_reg <= pend_next;
        end
    end

    // Busy reflects the post-edge scoreboard so it agrees with forwarded data.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rd1_reg   <= '0;
            rd2_reg   <= '0;
            busy1_reg <= 1'b0;
            busy2_reg <= 1'b0;
        end else if (RE) begin
            rd1_reg   <= rd1_next;
            rd2_reg   <= rd2_next;
            busy1_reg <= pend_next[A1];
            busy2_reg <= pend_next[A2];
        end
    end

    assign RD1   = rd1_reg;
    assign RD2   = rd2_reg;
    assign BUSY1 = busy1_reg;
    assign BUSY2 = busy2_reg;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Drives four parameter variants of regfile_scoreboard from one stimulus stream and
// checks them every cycle against an array-based reference, plus literal spot checks.
module tb_regfile_scoreboard;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [4:0]  A1 = '0, A2 = '0, A3 = '0, IA = '0;
    logic [31:0] WD = '0;
    logic        RE = 1'b0, RegWrite = 1'b0, ISSUE = 1'b0;

    logic [31:0] rd1_o [4];
    logic [31:0] rd2_o [4];
    logic [3:0]  busy1_o, busy2_o;
    logic [15:0] s_rd1, s_rd2;

    int n_vec = 0;
    int n_err = 0;

    // variant table: 0 default, 1 no bypass, 2 no zero reg, 3 narrow (16b x 8)
    int cfg_dw [4] = '{32, 32, 32, 16};
    int cfg_aw [4] = '{5, 5, 5, 3};
    int cfg_zr [4] = '{1, 1, 0, 0};
    int cfg_by [4] = '{1, 0, 1, 1};

    logic [31:0] m_reg  [4][32];
    bit          m_pend [4][32];
    logic [31:0] e_rd1 [4];
    logic [31:0] e_rd2 [4];
    bit          e_b1 [4];
    bit          e_b2 [4];

    always #5 CLK = ~CLK;

    regfile_scoreboard u_def (
        .CLK(CLK), .RST_N(RST_N), .A1(A1), .A2(A2), .RE(RE), .A3(A3), .WD(WD),
        .RegWrite(RegWrite), .ISSUE(ISSUE), .IA(IA),
        .RD1(rd1_o[0]), .RD2(rd2_o[0]), .BUSY1(busy1_o[0]), .BUSY2(busy2_o[0])
    );

    regfile_scoreboard #(.BYPASS(0)) u_nobyp (
        .CLK(CLK), .RST_N(RST_N), .A1(A1), .A2(A2), .RE(RE), .A3(A3), .WD(WD),
        .RegWrite(RegWrite), .ISSUE(ISSUE), .IA(IA),
        .RD1(rd1_o[1]), .RD2(rd2_o[1]), .BUSY1(busy1_o[1]), .BUSY2(busy2_o[1])
    );

    regfile_scoreboard #(.ZERO_REG(0)) u_nozero (
        .CLK(CLK), .RST_N(RST_N), .A1(A1), .A2(A2), .RE(RE), .A3(A3), .WD(WD),
        .RegWrite(RegWrite), .ISSUE(ISSUE), .IA(IA),
        .RD1(rd1_o[2]), .RD2(rd2_o[2]), .BUSY1(busy1_o[2]), .BUSY2(busy2_o[2])
    );

    regfile_scoreboard #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0)) u_small (
        .CLK(CLK), .RST_N(RST_N), .A1(A1[2:0]), .A2(A2[2:0]), .RE(RE), .A3(A3[2:0]),
        .WD(WD[15:0]), .RegWrite(RegWrite), .ISSUE(ISSUE), .IA(IA[2:0]),
        .RD1(s_rd1), .RD2(s_rd2), .BUSY1(busy1_o[3]), .BUSY2(busy2_o[3])
    );

    assign rd1_o[3] = {16'h0000, s_rd1};
    assign rd2_o[3] = {16'h0000, s_rd2};

    task automatic model_step(input int c);
        int          am, a1, a2, a3, ia;
        logic [31:0] dm, wd;
        bit          pn [32];
        am = (1 << cfg_aw[c]) - 1;
        dm = (cfg_dw[c] == 32) ? 32'hFFFF_FFFF : ((32'h1 << cfg_dw[c]) - 32'h1);
        a1 = int'(A1) & am;
        a2 = int'(A2) & am;
        a3 = int'(A3) & am;
        ia = int'(IA) & am;
        wd = WD & dm;
        for (int r = 0; r <= am; r++) begin
            pn[r] = (m_pend[c][r] && !(RegWrite && a3 == r)) || (ISSUE && ia == r);
            if (cfg_zr[c] != 0 && r == 0) pn[r] = 1'b0;
        end
        if (RE) begin
            if (cfg_zr[c] != 0 && a1 == 0)                    e_rd1[c] = '0;
            else if (cfg_by[c] != 0 && RegWrite && a3 == a1)  e_rd1[c] = wd;
            else                                              e_rd1[c] = m_reg[c][a1];
            if (cfg_zr[c] != 0 && a2 == 0)                    e_rd2[c] = '0;
            else if (cfg_by[c] != 0 && RegWrite && a3 == a2)  e_rd2[c] = wd;
            else                                              e_rd2[c] = m_reg[c][a2];
            e_b1[c] = pn[a1];
            e_b2[c] = pn[a2];
        end
        if (RegWrite && !(cfg_zr[c] != 0 && a3 == 0)) m_reg[c][a3] = wd;
        for (int r = 0; r <= am; r++) m_pend[c][r] = pn[r];
    endtask

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int c = 0; c < 4; c++) begin
                for (int r = 0; r < 32; r++) begin
                    m_reg[c][r]  = '0;
                    m_pend[c][r] = 1'b0;
                end
                e_rd1[c] = '0;
                e_rd2[c] = '0;
                e_b1[c]  = 1'b0;
                e_b2[c]  = 1'b0;
            end
        end else begin
            for (int c = 0; c < 4; c++) model_step(c);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("model cfg%0d RD1", c), rd1_o[c], e_rd1[c]);
            chk($sformatf("model cfg%0d RD2", c), rd2_o[c], e_rd2[c]);
            chk($sformatf("model cfg%0d BUSY1", c), {31'b0, busy1_o[c]}, {31'b0, e_b1[c]});
            chk($sformatf("model cfg%0d BUSY2", c), {31'b0, busy2_o[c]}, {31'b0, e_b2[c]});
        end
    end

    // Inputs are applied 1 time unit after a rising edge; returns 1 unit after the next edge.
    task automatic drive(input logic re, input logic [4:0] a1, input logic [4:0] a2,
                         input logic rw, input logic [4:0] a3, input logic [31:0] wd,
                         input logic iss, input logic [4:0] ia);
        RE = re; A1 = a1; A2 = a2; RegWrite = rw; A3 = a3; WD = wd; ISSUE = iss; IA = ia;
        @(posedge CLK);
        #1;
        $display("txn re=%0b a1=%0d a2=%0d we=%0b a3=%0d wd=%08h iss=%0b ia=%0d -> rd1=%08h rd2=%08h b1=%0b b2=%0b",
                 re, a1, a2, rw, a3, wd, iss, ia, rd1_o[0], rd2_o[0], busy1_o[0], busy2_o[0]);
    endtask

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        chk("reset RD1", rd1_o[0], 32'h0);
        chk("reset BUSY1", {31'b0, busy1_o[0]}, 32'h0);
        RST_N = 1'b1;

        drive(1, 5, 5, 1, 5, 32'hDEAD_BEEF, 0, 0);
        chk("bypass r5 def", rd1_o[0], 32'hDEAD_BEEF);
        chk("bypass r5 small", rd1_o[3], 32'h0000_BEEF);
        drive(1, 5, 5, 0, 0, 32'h0, 0, 0);
        chk("r5 nobyp", rd1_o[1], 32'hDEAD_BEEF);

        #1 RST_N = 1'b0;
        #1;
        chk("async reset RD1", rd1_o[0], 32'h0);
        chk("async reset RD2", rd2_o[1], 32'h0);
        #1 RST_N = 1'b1;
        drive(1, 5, 5, 0, 0, 32'h0, 0, 0);
        chk("r5 after reset", rd1_o[0], 32'h0);

        drive(1, 7, 7, 1, 7, 32'h1234_5678, 0, 0);
        chk("bypass RD1", rd1_o[0], 32'h1234_5678);
        chk("bypass RD2", rd2_o[0], 32'h1234_5678);
        chk("nobyp old RD1", rd1_o[1], 32'h0);
        drive(1, 7, 7, 0, 0, 32'h0, 0, 0);
        chk("nobyp new RD1", rd1_o[1], 32'h1234_5678);

        drive(1, 0, 0, 1, 0, 32'hFFFF_FFFF, 1, 0);
        chk("zero RD1", rd1_o[0], 32'h0);
        chk("zero BUSY1", {31'b0, busy1_o[0]}, 32'h0);
        chk("nozero RD1", rd1_o[2], 32'hFFFF_FFFF);
        chk("nozero BUSY1", {31'b0, busy1_o[2]}, 32'h1);
        drive(1, 0, 0, 0, 0, 32'h0, 0, 0);
        chk("nozero r0 held", rd1_o[2], 32'hFFFF_FFFF);

        drive(1, 3, 3, 0, 0, 32'h0, 1, 3);
        chk("issue BUSY1", {31'b0, busy1_o[0]}, 32'h1);
        drive(1, 3, 3, 1, 3, 32'hA5, 0, 0);
        chk("retire BUSY1", {31'b0, busy1_o[0]}, 32'h0);
        chk("retire RD1", rd1_o[0], 32'hA5);
        drive(1, 3, 3, 1, 3, 32'h5A, 1, 3);
        chk("issue+retire BUSY1", {31'b0, busy1_o[0]}, 32'h1);

        for (int i = 1; i <= 3; i++) begin
            drive(0, 5'(i), 5'(i), 1, 2, 32'h55, 0, 0);
            chk("hold RD1", rd1_o[0], 32'h5A);
            chk("hold BUSY1", {31'b0, busy1_o[0]}, 32'h1);
        end
        drive(1, 2, 2, 0, 0, 32'h0, 0, 0);
        chk("release RD1", rd1_o[0], 32'h55);

        for (int i = 0; i < 8; i++) drive(0, 0, 0, 1, 5'(i), 32'h1000 + i, 0, 0);
        for (int i = 0; i < 4; i++) begin
            drive(1, 5'(i + 8), 5'(i + 20), 0, 0, 32'h0, 0, 0);
            chk("sweep RD1", rd1_o[3], 32'h1000 + i);
            chk("sweep RD2", rd2_o[3], 32'h1004 + i);
        end

        @(negedge CLK);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
